grayscale_histogram_ise: RTL and testbench
==========================================

// Module: grayscale_histogram_ise
// PURPOSE
//  Multi-cycle custom instruction directly downstream of the RGB565->grayscale ISE.
//  Consumes its packed result word (4 x 8-bit gray pixels) and accumulates a grayscale histogram in an on-chip bin RAM.
//  The CPU reads bins back, reads the total pixel count, or clears the histogram using the same CI port.
//  Used for auto-exposure and thresholding in the camera pipeline.
// PARAMETERS
//  customInstructionId  8'd0  CI id; start is ignored unless ciN equals this value
//  BIN_WIDTH            20    bit width of each bin counter (640x480 = 307200 fits in 19 bits)
//  NUM_BINS_LOG2        8     log2 of the bin count; bin index = pixel[7 -: NUM_BINS_LOG2]; legal range 1..8
// PORTS
//  clock   in   1   system clock; all logic is on its rising edge
//  nReset  in   1   synchronous, active-low reset
//  ciN     in   8   custom instruction id
//  start   in   1   one-cycle request pulse; the CPU stalls until done
//  valueA  in   32  ACC: {p3,p2,p1,p0}, bytes packed as the grayscale ISE produces them; READ: bin index in [NUM_BINS_LOG2-1:0]
//  valueB  in   32  [1:0] = opcode (0 ACC, 1 READ, 2 CLEAR, 3 STATUS); [31:2] ignored
//  done    out  1   one-cycle completion pulse
//  result  out  32  valid only while done=1; forced to 32'd0 otherwise
// BEHAVIOUR
//  - Reset (nReset=0 at a clock edge): done=0, result=0, totalCount=0, pending=0, state=INIT, binIdx=0.
//  - INIT: writes 0 to one bin per cycle, 2^NUM_BINS_LOG2 cycles, then goes to IDLE. Bin RAM is never reset directly.
//  - States: INIT, IDLE, ACC_RD, ACC_WR, READ, CLEAR, DONE.
//  - A start with a matching ciN is accepted only in IDLE or INIT. During INIT it is latched (pending, with opcode and operands) and executed on the first IDLE cycle.
//  - A start in any other state is ignored (protocol violation); no side effects.
//  - ACC (start at cycle T): ACC_RD/ACC_WR alternate for p0..p3. Each pixel does a RAM read, then a write of bin+1. Pixels are processed strictly sequentially, so repeated values in one word need no forwarding.
//  - ACC: done=1 at T+9. result = totalCount after adding 4; totalCount is 32-bit and wraps.
//  - READ: RAM read latency is 1 cycle. done at T+2; result = zero-extended bin.
//  - CLEAR: as INIT, plus totalCount := 0. done at T+1+2^NUM_BINS_LOG2; result = 0.
//  - STATUS: done at T+1; result = totalCount.
//  - Bin overflow: see CONFIGURATION.
//  - Reset mid-operation: aborts the current operation with no done pulse, then re-runs INIT.
//  - A start coincident with nReset=0 is dropped.
//  - done is high for exactly one cycle per accepted start; result returns to 0 in the following cycle.
// CONFIGURATION
//  HIST_SATURATE_EN defined:     bin increment saturates at {BIN_WIDTH{1'b1}}.
//  HIST_SATURATE_EN not defined: bin increment wraps modulo 2^BIN_WIDTH.
//  totalCount wraps in both builds.
// STRUCTURE
//  Package grayscale_hist_pkg holds:
//   - opcode localparams OP_ACC=2'd0, OP_READ=2'd1, OP_CLEAR=2'd2, OP_STATUS=2'd3;
//   - the state encoding localparams;
//   - the ACC/READ/STATUS latency constants the bench uses.
//  Sub-module hist_bin_ram:
//   - single-port synchronous RAM, depth 2^NUM_BINS_LOG2, width BIN_WIDTH;
//   - ports: addr, we, wdata, rdata; 1-cycle read latency;
//   - infers block RAM.
//  The top level holds the FSM, pixel lane mux, incrementer, totalCount and pending latch.
// TESTING
//  1. Reset, then STATUS as soon as INIT ends -> result=0; READ bin 0x00 and bin 0xFF -> 0.
//  2. ACC valueA=0x10203040 -> done at T+9, result=4; READ 0x10/0x20/0x30/0x40 -> 1 each; READ 0x11 -> 0.
//  3. ACC valueA=0x7F7F7F7F three times -> READ 0x7F = 12, STATUS = 12; CLEAR -> READ 0x7F = 0, STATUS = 0.
//  4. BIN_WIDTH=4, 5 x ACC 0x00000000 (20 hits): HIST_SATURATE_EN build -> READ 0 = 15; plain build -> READ 0 = 4.
//  5. start during INIT (ACC 0x01010101) -> held, executed after INIT; READ 0x01 = 4.
//     start with ciN != id -> no done, no state change.
//  6. nReset low in the middle of an ACC -> no done; after INIT all bins = 0 and STATUS = 0.
//     NUM_BINS_LOG2=4: ACC 0xF0E01000 -> READ 0xF/0xE/0x1/0x0 = 1 each.

Source files
------------

// File: rtl/grayscale_hist_pkg.sv
// Shared constants for the grayscale histogram custom instruction: opcodes,
// FSM state encoding and the fixed operation latencies.
package grayscale_hist_pkg;

  localparam int unsigned CI_DATA_W = 32;
  localparam int unsigned CI_ID_W   = 8;

  localparam logic [1:0] OP_ACC    = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ACC_RD = 3'd2;
  localparam logic [2:0] ST_ACC_WR = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;
  localparam logic [2:0] ST_CLEAR  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACC_RD = ST_ACC_RD,
    S_ACC_WR = ST_ACC_WR,
    S_READ   = ST_READ,
    S_CLEAR  = ST_CLEAR,
    S_DONE   = ST_DONE
  } state_e;

  // Cycles from the accepting clock edge to the edge that raises done.
  localparam int unsigned LAT_ACC    = 9;
  localparam int unsigned LAT_READ   = 2;
  localparam int unsigned LAT_STATUS = 1;

endpackage

// File: rtl/grayscale_histogram_ise_if.sv
// Custom-instruction port bundle between the CPU (master) and the histogram unit (slave).
interface grayscale_histogram_ise_if;
  import grayscale_hist_pkg::*;

  logic [CI_ID_W-1:0]   ciN;
  logic                 start;
  logic [CI_DATA_W-1:0] valueA;
  logic [CI_DATA_W-1:0] valueB;
  logic                 done;
  logic [CI_DATA_W-1:0] result;

  modport master (output ciN, start, valueA, valueB, input done, result);
  modport slave  (input ciN, start, valueA, valueB, output done, result);
endinterface

// File: rtl/hist_bin_ram.sv
// Single-port synchronous bin RAM, read-first, one cycle read latency.
module hist_bin_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 20
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // No reset: contents are cleared by the controller's INIT sweep.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/grayscale_histogram_ise.sv
// Grayscale histogram custom instruction: ACC / READ / CLEAR / STATUS over a bin RAM.
// Build option HIST_SATURATE_EN makes bin increments saturate instead of wrap.
module grayscale_histogram_ise
  import grayscale_hist_pkg::*;
#(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned BIN_WIDTH           = 20,
  parameter int unsigned NUM_BINS_LOG2       = 8
) (
  input  logic                      clock,
  input  logic                      nReset,
  grayscale_histogram_ise_if.slave  ci
);

  localparam int unsigned AW = NUM_BINS_LOG2;
  localparam int unsigned BW = BIN_WIDTH;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CI_DATA_W-1:0] a_q, a_d;
  logic [1:0]           lane_q, lane_d;
  logic [AW-1:0]        bin_idx_q, bin_idx_d;
  logic [CI_DATA_W-1:0] total_q, total_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic [CI_DATA_W-1:0] result_q, result_d;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [BW-1:0] ram_wdata;
  logic [BW-1:0] ram_rdata;

  logic          start_ok;
  logic [7:0]    cur_pix;
  logic [AW-1:0] cur_bin;
  logic [BW-1:0] bin_inc;
  logic [1:0]    dop;
  logic [CI_DATA_W-1:0] da;
  logic          unused_ok;

  hist_bin_ram #(.ADDR_W(AW), .DATA_W(BW)) u_ram (
    .clk   (clock),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign start_ok  = ci.start && (ci.ciN == customInstructionId);
  assign cur_pix   = a_q[{lane_q, 3'b000} +: 8];
  assign cur_bin   = cur_pix[7 -: AW];
  assign unused_ok = ^{ci.valueB[CI_DATA_W-1:2], cur_pix};

`ifdef HIST_SATURATE_EN
  assign bin_inc = (&ram_rdata) ? ram_rdata : ram_rdata + BW'(1);
`else
  assign bin_inc = ram_rdata + BW'(1);
`endif

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q   <= S_INIT;
      op_q      <= OP_ACC;
      a_q       <= '0;
      lane_q    <= '0;
      bin_idx_q <= '0;
      total_q   <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      lane_q    <= lane_d;
      bin_idx_q <= bin_idx_d;
      total_q   <= total_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  // Next-state, RAM port and output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    lane_d    = lane_q;
    bin_idx_d = bin_idx_q;
    total_d   = total_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    result_d  = '0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    dop       = pend_q ? op_q : ci.valueB[1:0];
    da        = pend_q ? a_q  : ci.valueA;

    unique case (state_q)
      S_INIT, S_CLEAR: begin
        ram_addr  = bin_idx_q;
        ram_we    = 1'b1;
        bin_idx_d = bin_idx_q + AW'(1);
        if (bin_idx_q == {AW{1'b1}}) state_d = (state_q == S_INIT) ? S_IDLE : S_DONE;
        // A request arriving during INIT is parked until the sweep finishes.
        if (state_q == S_INIT && start_ok && !pend_q) begin
          pend_d = 1'b1;
          op_d   = ci.valueB[1:0];
          a_d    = ci.valueA;
        end
      end
      S_IDLE: begin
        if (pend_q || start_ok) begin
          pend_d = 1'b0;
          op_d   = dop;
          a_d    = da;
          unique case (dop)
            OP_ACC: begin
              total_d = total_q + 32'd4;
              lane_d  = '0;
              state_d = S_ACC_RD;
            end
            OP_READ:  state_d = S_READ;
            OP_CLEAR: begin
              total_d   = '0;
              bin_idx_d = '0;
              state_d   = S_CLEAR;
            end
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_ACC_RD: begin
        ram_addr = cur_bin;
        state_d  = S_ACC_WR;
      end
      S_ACC_WR: begin
        ram_addr  = cur_bin;
        ram_we    = 1'b1;
        ram_wdata = bin_inc;
        lane_d    = lane_q + 2'd1;
        state_d   = (lane_q == 2'd3) ? S_DONE : S_ACC_RD;
      end
      S_READ: begin
        ram_addr = a_q[AW-1:0];
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = (op_q == OP_READ) ? 32'(ram_rdata) : total_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign ci.done   = done_q;
  assign ci.result = result_q;

endmodule

// File: tb/tb_grayscale_histogram_ise.sv
// Directed self-checking bench for grayscale_histogram_ise (default, BIN_WIDTH=4, NUM_BINS_LOG2=4).
module tb_grayscale_histogram_ise;
  import grayscale_hist_pkg::*;

  logic clk = 1'b0;
  logic [2:0] rst_n;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  grayscale_histogram_ise_if if0();
  grayscale_histogram_ise_if if1();
  grayscale_histogram_ise_if if2();

  grayscale_histogram_ise dut0 (.clock(clk), .nReset(rst_n[0]), .ci(if0));
  grayscale_histogram_ise #(.BIN_WIDTH(4)) dut1 (.clock(clk), .nReset(rst_n[1]), .ci(if1));
  grayscale_histogram_ise #(.NUM_BINS_LOG2(4)) dut2 (.clock(clk), .nReset(rst_n[2]), .ci(if2));

  task automatic drive(input int w, input logic [7:0] c, input logic s,
                       input logic [31:0] a, input logic [1:0] op);
    case (w)
      0: begin if0.ciN = c; if0.start = s; if0.valueA = a; if0.valueB = {30'd0, op}; end
      1: begin if1.ciN = c; if1.start = s; if1.valueA = a; if1.valueB = {30'd0, op}; end
      default: begin if2.ciN = c; if2.start = s; if2.valueA = a; if2.valueB = {30'd0, op}; end
    endcase
  endtask

  task automatic sample(input int w, output logic d, output logic [31:0] r);
    case (w)
      0: begin d = if0.done; r = if0.result; end
      1: begin d = if1.done; r = if1.result; end
      default: begin d = if2.done; r = if2.result; end
    endcase
  endtask

  // Issue one CI request and wait (bounded) for done; also samples the cycle after done.
  task automatic ci_op(input int w, input logic [7:0] c, input logic [1:0] op, input logic [31:0] a,
                       input int budget, output logic got, output int lat, output logic [31:0] res,
                       output logic nd, output logic [31:0] nr);
    logic d;
    logic [31:0] r;
    @(negedge clk);
    drive(w, c, 1'b1, a, op);
    @(posedge clk);
    #1;
    drive(w, 8'd0, 1'b0, 32'd0, OP_ACC);
    got = 1'b0; lat = 0; res = 32'd0; nd = 1'b0; nr = 32'd0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      sample(w, d, r);
      if (d === 1'b1) begin
        got = 1'b1; lat = k; res = r;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
      sample(w, nd, nr);
    end
  endtask

  task automatic do_reset(input int w, input int init_cycles);
    @(negedge clk);
    rst_n[w] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[w] = 1'b1;
    repeat (init_cycles) @(posedge clk);
  endtask

  task automatic test_reset();
    logic d; logic [31:0] r; logic got, nd; int lat; logic [31:0] res, nr;
    rst_n = 3'b000;
    drive(0, 8'd0, 1'b0, 32'd0, OP_ACC);
    drive(1, 8'd0, 1'b0, 32'd0, OP_ACC);
    drive(2, 8'd0, 1'b0, 32'd0, OP_ACC);
    repeat (2) @(posedge clk);
    #1;
    sample(0, d, r);
    total++; if (d !== 1'b0) $display("FAIL reset_done got=%b exp=0", d); else passed++;
    total++; if (r !== 32'd0) $display("FAIL reset_result got=%h exp=0", r); else passed++;
    @(negedge clk);
    rst_n = 3'b111;
    repeat (256) @(posedge clk);
    ci_op(0, 8'd0, OP_STATUS, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (lat !== int'(LAT_STATUS)) $display("FAIL status_latency got=%0d exp=%0d", lat, LAT_STATUS); else passed++;
    total++; if (res !== 32'd0) $display("FAIL status_after_init got=%0d exp=0", res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'h00, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0 || !got) $display("FAIL read_bin00 got=%0d exp=0", res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'hFF, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0 || !got) $display("FAIL read_binFF got=%0d exp=0", res); else passed++;
  endtask

  task automatic test_acc();
    logic [7:0] idx [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11};
    logic [31:0] exp [5] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
    logic got, nd; int lat; logic [31:0] res, nr;
    ci_op(0, 8'd0, OP_ACC, 32'h10203040, 20, got, lat, res, nd, nr);
    total++; if (lat !== int'(LAT_ACC)) $display("FAIL acc_latency got=%0d exp=%0d", lat, LAT_ACC); else passed++;
    total++; if (res !== 32'd4) $display("FAIL acc_result got=%0d exp=4", res); else passed++;
    total++; if (nd !== 1'b0 || nr !== 32'd0) $display("FAIL acc_done_one_cycle got=%b/%h exp=0/0", nd, nr); else passed++;
    for (int i = 0; i < 5; i++) begin
      ci_op(0, 8'd0, OP_READ, {24'd0, idx[i]}, 10, got, lat, res, nd, nr);
      total++;
      if (res !== exp[i] || lat !== int'(LAT_READ))
        $display("FAIL read_bin_%h got=%0d lat=%0d exp=%0d lat=%0d", idx[i], res, lat, exp[i], LAT_READ);
      else passed++;
    end
  endtask

  task automatic test_repeat_clear();
    logic got, nd; int lat; logic [31:0] res, nr;
    ci_op(0, 8'd0, OP_CLEAR, 32'd0, 400, got, lat, res, nd, nr);
    total++; if (lat !== 257 || res !== 32'd0) $display("FAIL clear_latency got=%0d/%0d exp=257/0", lat, res); else passed++;
    for (int i = 1; i <= 3; i++) begin
      ci_op(0, 8'd0, OP_ACC, 32'h7F7F7F7F, 20, got, lat, res, nd, nr);
      total++; if (res !== 32'(4 * i)) $display("FAIL acc7f_result_%0d got=%0d exp=%0d", i, res, 4 * i); else passed++;
    end
    ci_op(0, 8'd0, OP_READ, 32'h7F, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd12) $display("FAIL read_7f got=%0d exp=12", res); else passed++;
    ci_op(0, 8'd0, OP_STATUS, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd12) $display("FAIL status_12 got=%0d exp=12", res); else passed++;
    ci_op(0, 8'd0, OP_CLEAR, 32'd0, 400, got, lat, res, nd, nr);
    ci_op(0, 8'd0, OP_READ, 32'h7F, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL read_7f_cleared got=%0d exp=0", res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'h10, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL read_10_cleared got=%0d exp=0", res); else passed++;
    ci_op(0, 8'd0, OP_STATUS, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL status_cleared got=%0d exp=0", res); else passed++;
  endtask

  task automatic test_ci_mismatch();
    logic got, nd; int lat; logic [31:0] res, nr;
    ci_op(0, 8'h55, OP_ACC, 32'h7F7F7F7F, 20, got, lat, res, nd, nr);
    total++; if (got !== 1'b0) $display("FAIL ci_mismatch_done got=%b exp=0", got); else passed++;
    ci_op(0, 8'd0, OP_STATUS, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (lat !== 1 || res !== 32'd0) $display("FAIL ci_mismatch_status got=%0d/%0d exp=1/0", lat, res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'h7F, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL ci_mismatch_bin got=%0d exp=0", res); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic got, nd, d; int lat, seen; logic [31:0] res, nr, r;
    ci_op(0, 8'd0, OP_ACC, 32'hAAAAAAAA, 20, got, lat, res, nd, nr);
    total++; if (res !== 32'd4) $display("FAIL acc_aa_result got=%0d exp=4", res); else passed++;
    seen = 0;
    @(negedge clk);
    drive(0, 8'd0, 1'b1, 32'h55555555, OP_ACC);
    @(posedge clk);
    #1;
    drive(0, 8'd0, 1'b0, 32'd0, OP_ACC);
    repeat (4) begin @(posedge clk); #1; sample(0, d, r); if (d === 1'b1) seen++; end
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    sample(0, d, r);
    if (d === 1'b1) seen++;
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (256) begin @(posedge clk); #1; sample(0, d, r); if (d === 1'b1) seen++; end
    total++; if (seen !== 0) $display("FAIL reset_mid_acc_done got=%0d exp=0", seen); else passed++;
    ci_op(0, 8'd0, OP_STATUS, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (lat !== 1 || res !== 32'd0) $display("FAIL reset_mid_status got=%0d/%0d exp=1/0", lat, res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'hAA, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL reset_mid_bin_aa got=%0d exp=0", res); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'h55, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL reset_mid_bin_55 got=%0d exp=0", res); else passed++;
  endtask

  task automatic test_pending();
    logic got, nd; int lat; logic [31:0] res, nr;
    do_reset(0, 10);
    ci_op(0, 8'd0, OP_ACC, 32'h01010101, 400, got, lat, res, nd, nr);
    total++; if (got !== 1'b1 || res !== 32'd4) $display("FAIL pending_acc got=%b/%0d exp=1/4", got, res); else passed++;
    total++; if (lat < 246) $display("FAIL pending_after_init got=%0d exp>=246", lat); else passed++;
    ci_op(0, 8'd0, OP_READ, 32'h01, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd4) $display("FAIL pending_bin01 got=%0d exp=4", res); else passed++;
  endtask

  task automatic test_bin_overflow();
    logic got, nd; int lat; logic [31:0] res, nr;
`ifdef HIST_SATURATE_EN
    logic [31:0] exp_bin = 32'd15;
`else
    logic [31:0] exp_bin = 32'd4;
`endif
    for (int i = 1; i <= 5; i++) ci_op(1, 8'd0, OP_ACC, 32'd0, 20, got, lat, res, nd, nr);
    total++; if (res !== 32'd20) $display("FAIL bw4_total got=%0d exp=20", res); else passed++;
    ci_op(1, 8'd0, OP_READ, 32'd0, 10, got, lat, res, nd, nr);
    total++; if (res !== exp_bin) $display("FAIL bw4_bin0 got=%0d exp=%0d", res, exp_bin); else passed++;
    ci_op(1, 8'd0, OP_READ, 32'd1, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL bw4_bin1 got=%0d exp=0", res); else passed++;
  endtask

  task automatic test_small_bins();
    logic [3:0] idx [5] = '{4'hF, 4'hE, 4'h1, 4'h0, 4'h2};
    logic [31:0] exp [5] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
    logic got, nd; int lat; logic [31:0] res, nr;
    ci_op(2, 8'd0, OP_ACC, 32'hF0E01000, 20, got, lat, res, nd, nr);
    total++; if (lat !== 9 || res !== 32'd4) $display("FAIL n4_acc got=%0d/%0d exp=9/4", lat, res); else passed++;
    for (int i = 0; i < 5; i++) begin
      ci_op(2, 8'd0, OP_READ, {28'd0, idx[i]}, 10, got, lat, res, nd, nr);
      total++; if (res !== exp[i]) $display("FAIL n4_bin_%h got=%0d exp=%0d", idx[i], res, exp[i]); else passed++;
    end
    ci_op(2, 8'd0, OP_CLEAR, 32'd0, 40, got, lat, res, nd, nr);
    total++; if (lat !== 17 || res !== 32'd0) $display("FAIL n4_clear got=%0d/%0d exp=17/0", lat, res); else passed++;
    ci_op(2, 8'd0, OP_READ, 32'hF, 10, got, lat, res, nd, nr);
    total++; if (res !== 32'd0) $display("FAIL n4_bin_f_cleared got=%0d exp=0", res); else passed++;
  endtask

  initial begin
    test_reset();
    test_acc();
    test_repeat_clear();
    test_ci_mismatch();
    test_reset_mid_op();
    test_pending();
    test_bin_overflow();
    test_small_bins();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
